tdm_frame_sched: RTL

// - Builds the 256-bit, 8-channel x 32-bit TDM frame consumed by p2tdm (pdata/valid), one frame per frame_tick.
// - Arbitrates NREQ sample producers (network decoders, mixers) round-robin onto one frame-buffer write port.
// - Handles missing samples (hold or mute); counts underruns and overwrites; accumulates p2tdm incr pulses into stat counters.
// - Entirely in the clk domain.

---
 rtl/tdm_frame_sched.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/tdm_frame_sched.sv
// tdm_frame_sched
//   Assembles one NCH x SW TDM frame per frame_tick for p2tdm. NREQ sample
//   producers are arbitrated round-robin onto a single frame-buffer write
//   port. Channels not written during a frame are either muted or repeat the
//   previously sent sample. Saturating statistics counters track underruns,
//   overwrites and the p2tdm status pulses.
//
// Ports
//   clk, rstn                     clock, asynchronous active-low reset
//   enable                        scheduler enable (same as p2tdm enable)
//   mute_missing                  1: unfilled channel sent as 0, 0: hold last
//   frame_tick                    one-cycle strobe at the frame rate
//   req / req_ch / req_data       per-requester request, channel, sample
//   gnt                           one-hot combinational grant
//   pdata / valid                 registered frame and one-cycle frame valid
//   bitslip_incr / retrans_incr / dropped_incr   p2tdm status pulses
//   clear_stats                   synchronous clear of all counters
//   *_cnt                         saturating statistics counters
//
// Handshake: a requester raises req[i] with req_ch/req_data and holds all
// three stable until it sees gnt[i]=1 in the same cycle; the write takes
// effect at that clock edge and the requester may then drop or change req.

module tdm_frame_sched #(
    parameter int NREQ = 4,
    parameter int NCH  = 8,
    parameter int SW   = 32,
    parameter int CNTW = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 enable,
    input  logic                 mute_missing,
    input  logic                 frame_tick,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*3-1:0]    req_ch,
    input  logic [NREQ*SW-1:0]   req_data,
    output logic [NREQ-1:0]      gnt,
    output logic [NCH*SW-1:0]    pdata,
    output logic                 valid,
    input  logic                 bitslip_incr,
    input  logic                 retrans_incr,
    input  logic                 dropped_incr,
    input  logic                 clear_stats,
    output logic [CNTW-1:0]      underrun_cnt,
    output logic [CNTW-1:0]      overwr_cnt,
    output logic [CNTW-1:0]      bitslip_cnt,
    output logic [CNTW-1:0]      retrans_cnt,
    output logic [CNTW-1:0]      dropped_cnt
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     rr_next;
    logic              found;
    logic [2:0]        wr_ch;
    logic [SW-1:0]     wr_data;
    logic [NCH-1:0]    fill;
    logic [NCH-1:0]    fill_next;
    logic [SW-1:0]     frame_buf [NCH];
    logic [SW-1:0]     hold      [NCH];
    logic [NCH*SW-1:0] emit_frame;
    logic              emit;
    logic              underrun_inc;
    logic              overwr_inc;

    assign emit = frame_tick & enable;

    // Round-robin search starting at rr_ptr; the outer loop is the search
    // distance, so the first hit is the nearest requester above the pointer.
    always_comb begin
        gnt     = '0;
        found   = 1'b0;
        wr_ch   = '0;
        wr_data = '0;
        rr_next = rr_ptr;
        if (enable && rstn) begin
            for (int k = 0; k < NREQ; k++) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (!found && req[i] && (i == (int'(rr_ptr) + k) % NREQ)) begin
                        gnt[i]  = 1'b1;
                        found   = 1'b1;
                        wr_ch   = req_ch[3*i +: 3];
                        wr_data = req_data[SW*i +: SW];
                        rr_next = PW'((i + 1) % NREQ);
                    end
                end
            end
        end
    end

    // Frame content as it would be emitted now, plus fill bookkeeping. A write
    // in the tick cycle belongs to the next frame, so fill is cleared first and
    // the new bit is set on top; such a write is never an overwrite.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            emit_frame[SW*c +: SW] = fill[c] ? frame_buf[c]
                                   : (mute_missing ? '0 : hold[c]);
        end
        underrun_inc = emit && (fill != '1);
        overwr_inc   = found && fill[wr_ch] && !emit;
        fill_next    = emit ? '0 : fill;
        if (found) begin
            fill_next[wr_ch] = 1'b1;
        end
    end

    function automatic logic [CNTW-1:0] cnt_next(input logic [CNTW-1:0] cur,
                                                 input logic            inc,
                                                 input logic            clr);
        if (clr) begin
            return '0;
        end
        if (inc && (cur != '1)) begin
            return cur + CNTW'(1);
        end
        return cur;
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pdata        <= '0;
            valid        <= 1'b0;
            fill         <= '0;
            rr_ptr       <= '0;
            underrun_cnt <= '0;
            overwr_cnt   <= '0;
            bitslip_cnt  <= '0;
            retrans_cnt  <= '0;
            dropped_cnt  <= '0;
            for (int c = 0; c < NCH; c++) begin
                frame_buf[c] <= '0;
                hold[c]      <= '0;
            end
        end else begin
            valid <= 1'b0;
            if (!enable) begin
                // Disabled: drop all partial frame state; pdata keeps the last frame.
                fill   <= '0;
                rr_ptr <= '0;
                for (int c = 0; c < NCH; c++) begin
                    frame_buf[c] <= '0;
                    hold[c]      <= '0;
                end
            end else begin
                fill <= fill_next;
                if (emit) begin
                    pdata <= emit_frame;
                    valid <= 1'b1;
                    for (int c = 0; c < NCH; c++) begin
                        hold[c] <= emit_frame[SW*c +: SW];
                    end
                end
                if (found) begin
                    frame_buf[wr_ch] <= wr_data;
                    rr_ptr           <= rr_next;
                end
            end
            underrun_cnt <= cnt_next(underrun_cnt, underrun_inc, clear_stats);
            overwr_cnt   <= cnt_next(overwr_cnt, overwr_inc, clear_stats);
            bitslip_cnt  <= cnt_next(bitslip_cnt, bitslip_incr & enable, clear_stats);
            retrans_cnt  <= cnt_next(retrans_cnt, retrans_incr & enable, clear_stats);
            dropped_cnt  <= cnt_next(dropped_cnt, dropped_incr & enable, clear_stats);
        end
    end

endmodule
